rr_arbiter_4: RTL and testbench
===============================

// Module: rr_arbiter_4
// PURPOSE
//   Round-robin arbiter sharing one resource between 4 requesters. Issues a
//   registered one-hot grant plus its 2-bit encoded index (0001->0, 0010->1,
//   0100->2, 1000->3). It sits in front of the shared datapath, and gnt_id
//   drives that datapath's select. The owner holds the grant until it
//   releases it or a hold timeout preempts it. Priority rotates on every
//   release.
// PARAMETERS
//   MAX_HOLD  16  max cycles a grant is held before forced release; 0 = no timeout
//   CNT_W     5   hold counter width; must be >= $clog2(MAX_HOLD+1)
// PORTS
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   req      in   4      request vector; bit k = requester k
//   done     in   1      current owner releases the grant (1-cycle pulse)
//   gnt      out  4      one-hot grant, registered; all-zero when idle
//   gnt_id   out  2      encoded index of gnt; holds last owner when idle
//   gnt_vld  out  1      1 while gnt != 0
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, gnt=0, gnt_id=0, gnt_vld=0, ptr=0,
//     hold_cnt=0. Reset mid-grant drops gnt at once and restarts at ptr=0.
//   State IDLE:
//     - If req != 0, select the first set bit scanning ptr, ptr+1, ... mod 4.
//     - Next edge: gnt=onehot(sel), gnt_id=sel, gnt_vld=1, hold_cnt=0, state=GRANT.
//     - Latency from req to gnt is 1 cycle.
//     - done is ignored in IDLE.
//   State GRANT (owner = gnt_id): release when any of these is true in a cycle:
//     (a) done=1
//     (b) req[owner]=0
//     (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
//     On release, next edge: gnt=0, gnt_vld=0, ptr=(owner+1) mod 4 (2-bit
//     wrap 3->0), state=IDLE; gnt_id keeps its value. Otherwise hold_cnt += 1.
//     gnt is unchanged by other requesters' req.
//   Turnaround: at least one idle cycle (gnt=0) between consecutive grants,
//     including a re-grant to the same requester.
//   Simultaneous events: done with req[owner]=0 in the same cycle is one
//     release (ptr advances once). A timeout coinciding with done is one
//     release.
//   Fairness: with all 4 requesting continuously, the grant order is
//     0,1,2,3,0,...
//   Invariants: gnt is 0 or one-hot; gnt_vld == |gnt; gnt_id == enc(gnt)
//     whenever gnt_vld=1.
// TESTING
//   1. Reset with req=4'b1111, release rst_n, hold req -> grants 0,1,2,3,0 in
//      order, each done-released, 1 idle cycle between grants.
//   2. req=4'b0100 only, ptr=0 -> gnt=4'b0100, gnt_id=2 one cycle after req;
//      drop req[2] -> gnt=0 next edge, ptr=3.
//   3. MAX_HOLD=4, req=4'b0001 held, done=0 -> gnt high exactly 4 cycles,
//      forced idle 1 cycle, then re-granted to 0.
//   4. Owner 3 releases with req=4'b1001 -> ptr wraps to 0, next gnt=4'b0001.
//   5. Assert rst_n=0 mid-grant (gnt=4'b0010) -> gnt=0, gnt_vld=0 immediately,
//      without a clock edge; after release, first grant follows ptr=0.
//   6. done pulse while IDLE with req=0 -> no grant and no ptr change;
//      invariants checked every cycle in all tests.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters: registered one-hot grant plus its
// encoded index, held until done, owner request drop, or hold timeout.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_vld
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam bit               TIMEOUT_EN = (MAX_HOLD != 0);

  state_t           r_state;
  logic [3:0]       r_gnt;
  logic [1:0]       r_gnt_id;
  logic             r_gnt_vld;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;

  logic [1:0]       w_sel;
  logic [1:0]       w_idx;
  logic             w_timeout;
  logic             w_release;

  // Scan from the highest offset down so the closest requester to r_ptr wins.
  always_comb begin
    w_sel = r_ptr;
    w_idx = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_ptr + 2'(i);
      if (req[w_idx]) begin
        w_sel = w_idx;
      end
    end
  end

  assign w_timeout = TIMEOUT_EN && (r_hold_cnt == HOLD_LAST);
  assign w_release = done | ~req[r_gnt_id] | w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_gnt_vld  <= 1'b0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_gnt      <= 4'b0001 << w_sel;
            r_gnt_id   <= w_sel;
            r_gnt_vld  <= 1'b1;
            r_hold_cnt <= '0;
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Any combination of release causes counts once; gnt_id is kept.
          if (w_release) begin
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
            r_ptr     <= r_gnt_id + 2'd1;
            r_state   <= ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign gnt_vld = r_gnt_vld;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4 (MAX_HOLD=4): a cycle model pushes the
// expected outputs per driven cycle, each test pops and compares them.
module tb_rr_arbiter_4;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_i;
  logic       done_i;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;

  int n_cmp;
  int n_err;

  // Reference model state
  bit   m_busy;
  int   m_id;
  int   m_ptr;
  int   m_cnt;
  logic [6:0] exp_q[$];

  rr_arbiter_4 #(.MAX_HOLD(MAXH), .CNT_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_i),
    .done    (done_i),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output invariants, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (gnt_vld !== (|gnt) || ((gnt & (gnt - 4'd1)) !== 4'd0) ||
          (gnt_vld && (gnt !== (4'b0001 << gnt_id)))) begin
        n_err++;
        $display("FAIL invariant t=%0t: gnt=%b gnt_id=%0d gnt_vld=%b", $time, gnt, gnt_id, gnt_vld);
      end
    end
  end

  task automatic model_reset();
    m_busy = 1'b0;
    m_id   = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    exp_q.delete();
  endtask

  // Drive one cycle, predict the outputs after the next edge, wait past it.
  task automatic step(input logic [3:0] r, input logic d);
    bit rel;
    int idx;
    req_i  = r;
    done_i = d;
    if (!m_busy) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (r[idx]) begin
          m_id   = idx;
          m_busy = 1'b1;
          m_cnt  = 0;
          break;
        end
      end
    end else begin
      rel = d || !r[m_id] || (MAXH != 0 && m_cnt == MAXH - 1);
      if (rel) begin
        m_busy = 1'b0;
        m_ptr  = (m_id + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    exp_q.push_back({(m_busy ? 4'(1 << m_id) : 4'b0000), 2'(m_id), m_busy});
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    req_i  = 4'b0000;
    done_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [6:0] got, exp;
    rst_n  = 1'b0;
    req_i  = 4'b1111;
    done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({gnt, gnt_id, gnt_vld} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_state: got gnt=%b id=%0d vld=%b, want all zero", gnt, gnt_id, gnt_vld);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(4'b1111, 1'b0);
    got = {gnt, gnt_id, gnt_vld};
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp || gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_first_grant: got %b want %b (gnt 0001)", got, exp);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] order [5];
    logic [6:0] got, exp;
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0);
      got = {gnt, gnt_id, gnt_vld};
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp || gnt !== order[i]) begin
        n_err++;
        $display("FAIL fairness_grant%0d: got %b want %b (gnt %b)", i, got, exp, order[i]);
      end
      step(4'b1111, 1'b1);
      got = {gnt, gnt_id, gnt_vld};
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp || gnt !== 4'b0000) begin
        n_err++;
        $display("FAIL fairness_idle%0d: got %b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_single_and_wrap();
    logic [3:0] r_seq [5];
    logic       d_seq [5];
    logic [3:0] g_seq [5];
    logic [6:0] got, exp;
    r_seq = '{4'b0100, 4'b0000, 4'b1111, 4'b1111, 4'b1001};
    d_seq = '{1'b0,    1'b0,    1'b0,    1'b1,    1'b0};
    g_seq = '{4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(r_seq[i], d_seq[i]);
      got = {gnt, gnt_id, gnt_vld};
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp || gnt !== g_seq[i]) begin
        n_err++;
        $display("FAIL single_wrap_cyc%0d: got %b want %b (gnt %b)", i, got, exp, g_seq[i]);
      end
    end
    n_cmp++;
    if (gnt_id !== 2'd0) begin
      n_err++;
      $display("FAIL wrap_gnt_id: got %0d want 0", gnt_id);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] g_seq [12];
    logic [6:0] got, exp;
    g_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001,
              4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001};
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      step(4'b0001, 1'b0);
      got = {gnt, gnt_id, gnt_vld};
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp || gnt !== g_seq[i]) begin
        n_err++;
        $display("FAIL timeout_cyc%0d: got %b want %b (gnt %b)", i, got, exp, g_seq[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] r_seq [9];
    logic       d_seq [9];
    logic [3:0] g_seq [9];
    logic [6:0] got, exp;
    r_seq = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b1111, 4'b1111};
    d_seq = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b1};
    g_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000};
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      step(r_seq[i], d_seq[i]);
      got = {gnt, gnt_id, gnt_vld};
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp || gnt !== g_seq[i]) begin
        n_err++;
        $display("FAIL simultaneous_cyc%0d: got %b want %b (gnt %b)", i, got, exp, g_seq[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] got, exp;
    apply_reset();
    step(4'b0010, 1'b0);
    got = {gnt, gnt_id, gnt_vld};
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp || gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL async_pre_grant: got %b want %b", got, exp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_id !== 2'd0) begin
      n_err++;
      $display("FAIL async_reset_drop: got gnt=%b vld=%b id=%0d want 0/0/0", gnt, gnt_vld, gnt_id);
    end
    req_i = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(4'b1111, 1'b0);
    got = {gnt, gnt_id, gnt_vld};
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp || gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL async_post_grant: got %b want %b (gnt 0001)", got, exp);
    end
  endtask

  task automatic test_done_idle();
    logic [3:0] r_seq [4];
    logic       d_seq [4];
    logic [3:0] g_seq [4];
    logic [6:0] got, exp;
    // Entered holding a grant to requester 0; releasing it leaves ptr=1.
    r_seq = '{4'b1111, 4'b0000, 4'b0000, 4'b1111};
    d_seq = '{1'b1,    1'b1,    1'b0,    1'b0};
    g_seq = '{4'b0000, 4'b0000, 4'b0000, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      step(r_seq[i], d_seq[i]);
      got = {gnt, gnt_id, gnt_vld};
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp || gnt !== g_seq[i]) begin
        n_err++;
        $display("FAIL done_idle_cyc%0d: got %b want %b (gnt %b)", i, got, exp, g_seq[i]);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    req_i  = 4'b0000;
    done_i = 1'b0;
    model_reset();
    test_reset();
    test_fairness();
    test_single_and_wrap();
    test_timeout();
    test_simultaneous();
    test_async_reset();
    test_done_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
